stream_xor_ctrl: RTL and testbench

STREAM_XOR_CTRL -- requirements
Module: stream_xor_ctrl

---
 rtl/stream_xor_ctrl.sv | 161 ++++++++++++++++
 tb/tb_stream_xor_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_xor_ctrl.sv
// Frame controller that XORs a plaintext byte stream with an external LFSR keystream.
// Optional feature: define XOR_CHKSUM_EN to add a running XOR checksum output (chksum).
module stream_xor_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] key,
    input  logic [7:0] frame_len,
    output logic       load_key_o,
    output logic [7:0] key_o,
    input  logic [7:0] keystream_i,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic       busy,
    output logic       done,
    output logic [7:0] byte_cnt
`ifdef XOR_CHKSUM_EN
    ,
    output logic [7:0] chksum
`endif
);

    typedef enum logic [1:0] {
        StIdle,
        StKeyload,
        StRun,
        StFlush
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] key_q, key_d;
    logic [7:0] len_q, len_d;
    logic [7:0] cnt_q, cnt_d;
    logic       done_q, done_d;

    logic [7:0] fifo_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] occ_q;

    logic       push;
    logic       pop;
    logic       start_ok;
    logic [7:0] push_data;

    assign start_ok  = (state_q == StIdle) && start && (frame_len != 8'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign push_data = in_data ^ keystream_i;

    // All handshake outputs come from registers only, so out_ready never reaches in_ready.
    assign in_ready   = (state_q == StRun) && (cnt_q < len_q) && (occ_q < 2'd2);
    assign out_valid  = (occ_q != 2'd0);
    assign out_data   = out_valid ? fifo_q[rd_ptr_q] : 8'd0;
    assign load_key_o = (state_q == StKeyload);
    assign key_o      = key_q;
    assign busy       = (state_q != StIdle);
    assign done       = done_q;
    assign byte_cnt   = cnt_q;

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_ok) begin
                    key_d   = key;
                    len_d   = frame_len;
                    cnt_d   = 8'd0;
                    state_d = StKeyload;
                end else if (start) begin
                    // Empty frame: report completion without touching the LFSR.
                    done_d = 1'b1;
                end
            end
            StKeyload: begin
                state_d = StRun;
            end
            StRun: begin
                if (push) begin
                    cnt_d = cnt_q + 8'd1;
                end
                if (cnt_q == len_q) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                if (occ_q == 2'd0) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            key_q   <= 8'd0;
            len_q   <= 8'd0;
            cnt_q   <= 8'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fifo_q[0] <= 8'd0;
            fifo_q[1] <= 8'd0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            occ_q     <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= push_data;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

`ifdef XOR_CHKSUM_EN
    logic [7:0] chk_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            chk_q <= 8'd0;
        end else if (start_ok) begin
            chk_q <= 8'd0;
        end else if (pop) begin
            chk_q <= chk_q ^ out_data;
        end
    end

    assign chksum = chk_q;
`endif

endmodule

// File: tb/tb_stream_xor_ctrl.sv
// Self-checking bench for stream_xor_ctrl with an attached LFSR and a transaction-level model.
// Checksum checks are compiled in when XOR_CHKSUM_EN is defined.
module tb_stream_xor_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] key;
    logic [7:0] frame_len;
    logic       load_key_o;
    logic [7:0] key_o;
    logic [7:0] keystream_i;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       busy;
    logic       done;
    logic [7:0] byte_cnt;
`ifdef XOR_CHKSUM_EN
    logic [7:0] chksum;
`endif

    stream_xor_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .key        (key),
        .frame_len  (frame_len),
        .load_key_o (load_key_o),
        .key_o      (key_o),
        .keystream_i(keystream_i),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .byte_cnt   (byte_cnt)
`ifdef XOR_CHKSUM_EN
        ,
        .chksum     (chksum)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic logic [7:0] lfsr_seed(input logic [7:0] k);
        return (k == 8'd0) ? 8'd1 : k;
    endfunction

    // Keystream source attached to the DUT.
    logic [7:0] lfsr = 8'd1;
    always @(posedge clk) begin
        if (load_key_o) lfsr <= lfsr_seed(key_o);
        else            lfsr <= lfsr_next(lfsr);
    end
    assign keystream_i = lfsr;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: 0 idle, 1 key load, 2 run, 3 flush.
    int         m_phase = 0;
    logic [7:0] m_key = 8'd0;
    logic [7:0] m_len = 8'd0;
    logic [7:0] m_cnt = 8'd0;
    logic [7:0] m_ks  = 8'd0;
    logic [7:0] m_chk = 8'd0;
    logic       m_done = 1'b0;
    logic [7:0] m_q[$];

    logic [7:0] obs[$];
    int n_done = 0;
    int n_load = 0;
    int n_busy = 0;

    function automatic logic [31:0] obs_at(input int i);
        return (i < obs.size()) ? 32'(obs[i]) : 32'hFFFF_FFFF;
    endfunction

    task automatic compare_outputs();
        check_eq("busy", 32'(busy), 32'(m_phase != 0));
        check_eq("load_key_o", 32'(load_key_o), 32'(m_phase == 1));
        check_eq("in_ready", 32'(in_ready),
                 32'((m_phase == 2) && (m_cnt < m_len) && (m_q.size() < 2)));
        check_eq("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) check_eq("out_data", 32'(out_data), 32'(m_q[0]));
        check_eq("byte_cnt", 32'(byte_cnt), 32'(m_cnt));
        check_eq("done", 32'(done), 32'(m_done));
        check_eq("key_o", 32'(key_o), 32'(m_key));
`ifdef XOR_CHKSUM_EN
        check_eq("chksum", 32'(chksum), 32'(m_chk));
`endif
        if (done) n_done++;
        if (load_key_o) n_load++;
        if (busy) n_busy++;
    endtask

    // One clock: drive inputs, advance the model, then compare at the next falling edge.
    task automatic step(input logic rst, input logic st, input logic [7:0] k,
                        input logic [7:0] l, input logic iv, input logic [7:0] id,
                        input logic ordy);
        logic       acc;
        logic       pp;
        int         old_phase;
        logic [7:0] ks_now;
        reset     = rst;
        start     = st;
        key       = k;
        frame_len = l;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        if (out_valid && ordy) obs.push_back(out_data);

        acc       = iv && (m_phase == 2) && (m_cnt < m_len) && (m_q.size() < 2);
        pp        = (m_q.size() != 0) && ordy;
        old_phase = m_phase;
        ks_now    = m_ks;
        m_done    = 1'b0;
        if (rst) begin
            m_phase = 0;
            m_key   = 8'd0;
            m_len   = 8'd0;
            m_cnt   = 8'd0;
            m_chk   = 8'd0;
            m_q.delete();
        end else begin
            case (m_phase)
                0: begin
                    if (st && l != 8'd0) begin
                        m_key   = k;
                        m_len   = l;
                        m_cnt   = 8'd0;
                        m_chk   = 8'd0;
                        m_phase = 1;
                    end else if (st) begin
                        m_done = 1'b1;
                    end
                end
                1: m_phase = 2;
                2: if (m_cnt == m_len) m_phase = 3;
                3: if (m_q.size() == 0) begin
                    m_phase = 0;
                    m_done  = 1'b1;
                end
                default: m_phase = 0;
            endcase
            if (pp) m_chk = m_chk ^ m_q.pop_front();
            if (acc) begin
                m_q.push_back(id ^ ks_now);
                m_cnt = m_cnt + 8'd1;
            end
        end
        m_ks = (old_phase == 1 && !rst) ? lfsr_seed(m_key) : lfsr_next(m_ks);
        @(negedge clk);
        compare_outputs();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; key = 8'd0; frame_len = 8'd0;
        in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        check_eq("rst_load", 32'(load_key_o), 32'd0);
        check_eq("rst_key_o", 32'(key_o), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_byte_cnt", 32'(byte_cnt), 32'd0);

        // Two zero bytes under key 0x5A.
        obs.delete(); n_done = 0;
        step(0, 1, 8'h5A, 8'd2, 1, 8'h00, 1);
        repeat (8) step(0, 0, 8'h00, 8'h00, 1, 8'h00, 1);
        check_eq("k5a_count", 32'(obs.size()), 32'd2);
        check_eq("k5a_byte0", obs_at(0), 32'h5A);
        check_eq("k5a_byte1", obs_at(1), 32'hB4);
        check_eq("k5a_done_pulses", 32'(n_done), 32'd1);
        check_eq("k5a_byte_cnt", 32'(byte_cnt), 32'd2);
`ifdef XOR_CHKSUM_EN
        check_eq("k5a_chksum", 32'(chksum), 32'hEE);
`endif

        // Zero key is replaced by 0x01 inside the LFSR.
        obs.delete();
        step(0, 1, 8'h00, 8'd1, 1, 8'h00, 1);
        repeat (7) step(0, 0, 8'h00, 8'h00, 1, 8'h00, 1);
        check_eq("zkey_count", 32'(obs.size()), 32'd1);
        check_eq("zkey_byte0", obs_at(0), 32'h01);

        // Backpressure: two bytes fill the buffer, then drain.
        obs.delete(); n_done = 0;
        step(0, 1, 8'hC3, 8'd4, 1, 8'h10, 0);
        repeat (7) step(0, 0, 8'h00, 8'h00, 1, 8'h10 + m_cnt, 0);
        check_eq("bp_in_ready", 32'(in_ready), 32'd0);
        check_eq("bp_byte_cnt", 32'(byte_cnt), 32'd2);
        check_eq("bp_no_output", 32'(obs.size()), 32'd0);
        repeat (12) step(0, 0, 8'h00, 8'h00, 1, 8'h10 + m_cnt, 1);
        check_eq("bp_count", 32'(obs.size()), 32'd4);
        check_eq("bp_done_pulses", 32'(n_done), 32'd1);

        // Empty frame.
        n_done = 0; n_load = 0; n_busy = 0;
        step(0, 1, 8'h77, 8'd0, 0, 8'h00, 1);
        repeat (3) step(0, 0, 8'h00, 8'h00, 0, 8'h00, 1);
        check_eq("empty_done", 32'(n_done), 32'd1);
        check_eq("empty_load", 32'(n_load), 32'd0);
        check_eq("empty_busy", 32'(n_busy), 32'd0);

        // Reset mid-frame after one of three bytes.
        step(0, 1, 8'h21, 8'd3, 1, 8'h33, 0);
        step(0, 0, 8'h00, 8'h00, 1, 8'h33, 0);
        step(0, 0, 8'h00, 8'h00, 1, 8'h34, 0);
        check_eq("mid_byte_cnt", 32'(byte_cnt), 32'd1);
        n_done = 0;
        step(1, 0, 8'h00, 8'h00, 1, 8'h35, 1);
        check_eq("mid_out_valid", 32'(out_valid), 32'd0);
        check_eq("mid_busy", 32'(busy), 32'd0);
        check_eq("mid_byte_cnt0", 32'(byte_cnt), 32'd0);
        repeat (4) step(0, 0, 8'h00, 8'h00, 1, 8'h00, 1);
        check_eq("mid_no_done", 32'(n_done), 32'd0);

        // Random frames with random handshakes, stray starts and one mid-frame reset.
        for (int f = 0; f < 12; f++) begin
            int guard;
            step(0, 1, 8'($urandom), 8'($urandom_range(1, 6)), 0, 8'h00, 1);
            guard = 0;
            while (m_phase != 0 && guard < 200) begin
                step(1'(f == 5 && guard == 6), 1'($urandom_range(0, 7) == 0), 8'($urandom),
                     8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom),
                     1'($urandom_range(0, 3) != 0));
                guard++;
            end
            check_eq("rand_frame_end", 32'(guard < 200), 32'd1);
            repeat (2) step(0, 0, 8'h00, 8'h00, 0, 8'h00, 1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
